// File: rtl/uart_input_loader.sv
// Assembles framed UART bytes (0x02 start + payload) into a parallel input vector
// and forwards every other idle-time byte as a command. Define INPUT_LOADER_CHECKSUM_EN
// to append and verify an XOR checksum byte after the payload.
module uart_input_loader #(
  parameter int NUM_INPUTS = 10,
  parameter int NUM_BYTES  = (NUM_INPUTS + 7) / 8,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic [NUM_INPUTS-1:0] o_inputs,
  output logic                  o_update,
  output logic                  o_cmd_valid,
  output logic [7:0]            o_cmd,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       START_BYTE = 8'h02;

`ifdef INPUT_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_COMMIT} state_t;
`endif

  state_t                  state;
  logic                    rx_valid_q;
  logic                    accept;
  logic [IDX_W-1:0]        byte_idx;
  logic [CNT_W-1:0]        gap_cnt;
  logic [NUM_INPUTS-1:0]   shadow;
  logic [NUM_INPUTS-1:0]   shadow_next;
`ifdef INPUT_LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  // One byte per rising edge of the receiver flag, however long it is held.
  assign accept = i_rx_valid & ~rx_valid_q;
  assign o_busy = (state != S_IDLE);

  // Byte k lands on bits [8k+7:8k]; bits at or above NUM_INPUTS simply do not exist.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_shadow_bit
    assign shadow_next[i] = (byte_idx == IDX_W'(i / 8)) ? i_rx_data[i % 8] : shadow[i];
  end

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      rx_valid_q  <= 1'b0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      shadow      <= '0;
      o_inputs    <= '0;
      o_update    <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'h00;
      o_err       <= 1'b0;
`ifdef INPUT_LOADER_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else begin
      rx_valid_q  <= i_rx_valid;
      o_update    <= 1'b0;
      o_cmd_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (i_rx_data == START_BYTE) begin
              shadow   <= '0;
              byte_idx <= '0;
              gap_cnt  <= '0;
`ifdef INPUT_LOADER_CHECKSUM_EN
              csum     <= 8'h00;
`endif
              state    <= S_PAYLOAD;
            end else begin
              o_cmd       <= i_rx_data;
              o_cmd_valid <= 1'b1;
            end
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            shadow  <= shadow_next;
            gap_cnt <= '0;
`ifdef INPUT_LOADER_CHECKSUM_EN
            csum    <= csum ^ i_rx_data;
`endif
            if (byte_idx == LAST_IDX) begin
`ifdef INPUT_LOADER_CHECKSUM_EN
              state <= S_CHECK;
`else
              state <= S_COMMIT;
`endif
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (gap_cnt == GAP_LAST) begin
            o_err   <= 1'b1;
            shadow  <= '0;
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

`ifdef INPUT_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            gap_cnt <= '0;
            if (i_rx_data == csum) begin
              state <= S_COMMIT;
            end else begin
              o_err  <= 1'b1;
              shadow <= '0;
              state  <= S_IDLE;
            end
          end else if (gap_cnt == GAP_LAST) begin
            o_err   <= 1'b1;
            shadow  <= '0;
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif

        S_COMMIT: begin
          o_inputs <= shadow;
          o_update <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_input_loader.sv
// Self-checking bench for uart_input_loader: a frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_input_loader;

  localparam int NUM_INPUTS = 10;
  localparam int NUM_BYTES  = (NUM_INPUTS + 7) / 8;
  localparam int TIMEOUT    = 100;
`ifdef INPUT_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int FRAME_LEN = NUM_BYTES + (CSUM_EN ? 1 : 0);

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_rx_valid;
  logic [7:0]            i_rx_data;
  logic [NUM_INPUTS-1:0] o_inputs;
  logic                  o_update;
  logic                  o_cmd_valid;
  logic [7:0]            o_cmd;
  logic                  o_busy;
  logic                  o_err;

  uart_input_loader #(
    .NUM_INPUTS(NUM_INPUTS),
    .NUM_BYTES (NUM_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_inputs   (o_inputs),
    .o_update   (o_update),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd      (o_cmd),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model, advanced on each rising clock edge.
  logic                  m_prev;
  bit                    m_in_frame;
  bit                    m_commit_pending;
  int                    m_gap;
  logic [7:0]            m_q[$];
  logic [NUM_INPUTS-1:0] m_pending;
  logic [NUM_INPUTS-1:0] exp_inputs;
  logic                  exp_update, exp_cmd_valid, exp_busy, exp_err;
  logic [7:0]            exp_cmd;

  always @(posedge i_clk) begin : model
    bit                     acc;
    bit                     committing;
    logic [8*NUM_BYTES-1:0] wide;
    logic [7:0]             x;
    if (i_rst) begin
      m_prev = 1'b0; m_in_frame = 0; m_commit_pending = 0; m_gap = 0; m_q.delete();
      exp_inputs = '0; exp_update = 0; exp_cmd_valid = 0; exp_cmd = 8'h00; exp_err = 0;
    end else begin
      exp_update = 0;
      exp_cmd_valid = 0;
      committing = m_commit_pending;
      if (m_commit_pending) begin
        exp_inputs = m_pending;
        exp_update = 1;
        m_commit_pending = 0;
      end
      acc = i_rx_valid && !m_prev;
      m_prev = i_rx_valid;
      if (m_in_frame) begin
        if (acc) begin
          m_q.push_back(i_rx_data);
          m_gap = 0;
          if (m_q.size() == FRAME_LEN) begin
            wide = '0;
            x = 8'h00;
            for (int k = 0; k < NUM_BYTES; k++) begin
              wide[8*k +: 8] = m_q[k];
              x ^= m_q[k];
            end
            m_in_frame = 0;
            if (CSUM_EN && m_q[FRAME_LEN-1] != x) exp_err = 1;
            else begin
              m_pending = wide[NUM_INPUTS-1:0];
              m_commit_pending = 1;
            end
          end
        end else begin
          m_gap++;
          if (m_gap == TIMEOUT) begin
            exp_err = 1;
            m_in_frame = 0;
          end
        end
      end else if (acc && !committing) begin
        if (i_rx_data == 8'h02) begin
          m_in_frame = 1;
          m_q.delete();
          m_gap = 0;
        end else begin
          exp_cmd = i_rx_data;
          exp_cmd_valid = 1;
        end
      end
    end
    exp_busy = m_in_frame || m_commit_pending;
  end

  always @(negedge i_clk) begin : compare
    check("inputs",    32'(o_inputs),  32'(exp_inputs));
    check("update",    32'(o_update),  32'(exp_update));
    check("cmd_valid", 32'(o_cmd_valid), 32'(exp_cmd_valid));
    check("cmd",       32'(o_cmd),     32'(exp_cmd));
    check("busy",      32'(o_busy),    32'(exp_busy));
    check("err",       32'(o_err),     32'(exp_err));
  end

  // Called at a falling edge; returns at a falling edge with i_rx_valid low.
  task automatic send_byte(input logic [7:0] d, input int hi, input int lo);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    repeat (hi) @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (lo) @(negedge i_clk);
  endtask

  task automatic send_rand(input logic [7:0] d);
    send_byte(d, $urandom_range(1, 6), $urandom_range(1, 4));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_inputs"},    32'(o_inputs),    32'h0);
    check({tag, "_update"},    32'(o_update),    32'h0);
    check({tag, "_cmd_valid"}, 32'(o_cmd_valid), 32'h0);
    check({tag, "_cmd"},       32'(o_cmd),       32'h0);
    check({tag, "_busy"},      32'(o_busy),      32'h0);
    check({tag, "_err"},       32'(o_err),       32'h0);
  endtask

  task automatic rand_frame(input bit bad_csum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_rand(8'h02);
    for (int k = 0; k < NUM_BYTES; k++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      send_rand(b);
    end
    if (CSUM_EN) send_rand(bad_csum ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  localparam logic [7:0]            LAST_A  = CSUM_EN ? 8'hA6 : 8'h03;
  localparam logic [NUM_INPUTS-1:0] PRIOR_D = CSUM_EN ? 10'h112 : 10'h3A5;

  initial begin
    logic [7:0] d;
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    repeat (3) @(negedge i_clk);
    check_reset_state("reset");
    i_rst = 1'b0;

    // 0x02 held high for 50 cycles is one start byte; then A5, 03 (+A6 checksum).
    i_rx_data = 8'h02; i_rx_valid = 1'b1;
    repeat (50) @(negedge i_clk);
    check("hold_busy", 32'(o_busy), 32'h1);
    check("hold_no_cmd", 32'(o_cmd_valid), 32'h0);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    send_byte(8'hA5, 2, 2);
    if (CSUM_EN) send_byte(8'h03, 1, 3);
    i_rx_data = LAST_A; i_rx_valid = 1'b1;
    @(negedge i_clk);
    check("lat_edge_update", 32'(o_update), 32'h0);
    check("lat_edge_inputs", 32'(o_inputs), 32'h0);
    @(negedge i_clk);
    check("lat2_update", 32'(o_update), 32'h1);
    check("lat2_inputs", 32'(o_inputs), 32'h3A5);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    check("lat3_update", 32'(o_update), 32'h0);
    check("lat3_busy",   32'(o_busy),   32'h0);

    // Command byte in IDLE.
    i_rx_data = 8'h01; i_rx_valid = 1'b1;
    @(negedge i_clk);
    check("cmd_pulse", 32'(o_cmd_valid), 32'h1);
    check("cmd_value", 32'(o_cmd), 32'h01);
    @(negedge i_clk);
    check("cmd_one_cycle", 32'(o_cmd_valid), 32'h0);
    check("cmd_inputs", 32'(o_inputs), 32'h3A5);
    i_rx_valid = 1'b0;
    @(negedge i_clk);

    if (CSUM_EN) begin
      send_byte(8'h02, 1, 1); send_byte(8'h12, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h13, 1, 3);
      check("csum_good_inputs", 32'(o_inputs), 32'h112);
      check("csum_good_err", 32'(o_err), 32'h0);
    end

    // Timeout: 02, FF, then idle. Error must appear exactly on the TIMEOUT-th idle edge.
    send_byte(8'h02, 1, 1);
    i_rx_data = 8'hFF; i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge i_clk);
    check("tmo_before_err", 32'(o_err), 32'h0);
    check("tmo_before_busy", 32'(o_busy), 32'h1);
    @(negedge i_clk);
    check("tmo_err", 32'(o_err), 32'h1);
    check("tmo_busy", 32'(o_busy), 32'h0);
    check("tmo_inputs", 32'(o_inputs), 32'(PRIOR_D));
    repeat (5) @(negedge i_clk);
    check("err_sticky", 32'(o_err), 32'h1);

    i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
    check("err_cleared", 32'(o_err), 32'h0);

    if (CSUM_EN) begin
      send_byte(8'h02, 1, 1); send_byte(8'h12, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h00, 1, 3);
      check("csum_bad_err", 32'(o_err), 32'h1);
      check("csum_bad_inputs", 32'(o_inputs), 32'h0);
      i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
    end

    // Reset mid-frame abandons it without an error, then a fresh frame commits.
    send_byte(8'h02, 1, 1); send_byte(8'h34, 1, 1);
    i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
    check_reset_state("midrst");
    send_byte(8'h02, 2, 1); send_byte(8'h34, 1, 2); send_byte(8'h01, 3, 1);
    if (CSUM_EN) send_byte(8'h35, 1, 1);
    @(negedge i_clk);
    check("after_rst_inputs", 32'(o_inputs), 32'h134);
    check("after_rst_err", 32'(o_err), 32'h0);

    // Flag already high when reset releases: accepted on the first edge.
    i_rst = 1'b1; i_rx_data = 8'h07; i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_release_cmd_valid", 32'(o_cmd_valid), 32'h1);
    check("rst_release_cmd", 32'(o_cmd), 32'h07);
    i_rx_valid = 1'b0;
    @(negedge i_clk);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          do d = 8'($urandom_range(0, 255)); while (d == 8'h02);
          send_rand(d);
        end
        8: begin
          send_rand(8'h02);
          for (int k = 0; k < int'($urandom_range(0, NUM_BYTES - 1)); k++)
            send_rand(8'($urandom_range(0, 255)));
          repeat (TIMEOUT + 3) @(negedge i_clk);
        end
        9: begin
          send_rand(8'h02);
          send_rand(8'($urandom_range(0, 255)));
          i_rst = 1'b1;
          repeat ($urandom_range(1, 2)) @(negedge i_clk);
          i_rst = 1'b0;
        end
        default: rand_frame($urandom_range(0, 9) == 0);
      endcase
    end

    repeat (4) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_input_loader.md
UART_INPUT_LOADER -- requirements
Module: uart_input_loader

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 10, the width of the assembled input vector.
REQ-002 The block SHALL have parameter NUM_BYTES, default (NUM_INPUTS+7)/8, the payload bytes per frame.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000000, the maximum clock cycles allowed between consecutive frame bytes.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_rx_valid, input, 1 bit: receiver done flag, which may be held high for many cycles.
REQ-007 The block SHALL have port i_rx_data, input, 8 bits: received byte, stable while i_rx_valid is high.
REQ-008 The block SHALL have port o_inputs, output, NUM_INPUTS bits: applied input vector for the redstone core.
REQ-009 The block SHALL have port o_update, output, 1 bit: one-cycle pulse when o_inputs changes by commit.
REQ-010 The block SHALL have port o_cmd_valid, output, 1 bit: one-cycle pulse forwarding a non-loader command byte.
REQ-011 The block SHALL have port o_cmd, output, 8 bits: the forwarded command byte, held until the next forward.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port o_err, output, 1 bit: sticky frame-error flag.

Function
REQ-014 A byte SHALL be accepted only on a 0->1 edge of i_rx_valid (registered previous value), so one byte is accepted per edge regardless of how long the flag is held.
REQ-015 The FSM SHALL have states IDLE, PAYLOAD, CHECK and COMMIT.
REQ-016 In IDLE, accepted byte 8'h02 SHALL clear the shadow register and byte index, then go to PAYLOAD.
REQ-017 In IDLE, any other accepted byte SHALL be copied to o_cmd with o_cmd_valid pulsed the next cycle; the state remains IDLE.
REQ-018 In PAYLOAD, byte k (k = 0..NUM_BYTES-1) SHALL be written to shadow bits [8k+7:8k], LSB-first; bits at or above NUM_INPUTS are discarded.
REQ-019 After byte NUM_BYTES-1, the FSM SHALL go to CHECK when INPUT_LOADER_CHECKSUM_EN is defined, else to COMMIT.
REQ-020 COMMIT SHALL last one cycle: it copies the shadow to o_inputs, pulses o_update, and returns to IDLE.
REQ-021 The latency from the last-byte edge to o_update high SHALL be 2 cycles without checksum; with checksum it is 2 cycles from the checksum-byte edge.
REQ-022 In PAYLOAD or CHECK, a gap counter SHALL reset on each accepted byte; reaching TIMEOUT SHALL set o_err, discard the shadow, and return to IDLE without changing o_inputs.
REQ-023 Bytes arriving in PAYLOAD or CHECK SHALL always be treated as data; command bytes SHALL NOT be forwarded mid-frame.
REQ-024 o_err SHALL clear on reset only.
REQ-025 o_inputs SHALL change only in COMMIT; a partial or failed frame SHALL never be visible on o_inputs.

Reset
REQ-026 With i_rst high at a clock edge, the block SHALL set: state IDLE; o_inputs 0; shadow 0; o_update 0; o_cmd_valid 0; o_cmd 8'h00; o_busy 0; o_err 0; gap counter 0; edge register 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame and leave no frame-error indication.
REQ-028 The edge register SHALL reset to 0, so if i_rx_valid is high at reset release, that byte is accepted on the first edge after reset.

Configuration
REQ-029 With INPUT_LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte and compare it with the XOR of all payload bytes: a match goes to COMMIT; a mismatch sets o_err and returns to IDLE with o_inputs unchanged.
REQ-030 With INPUT_LOADER_CHECKSUM_EN undefined, the CHECK state and the XOR logic SHALL be absent, and frames SHALL be exactly 1+NUM_BYTES bytes.

Verification (NUM_INPUTS=10, TIMEOUT=100)
REQ-031 Bytes 02, A5, 03 (no checksum) -> o_inputs=10'h3A5, one o_update pulse 2 cycles after the last edge.
REQ-032 i_rx_valid held high 50 cycles carrying 02 -> accepted once; state PAYLOAD, index 0.
REQ-033 Byte 01 in IDLE -> o_cmd=8'h01 and o_cmd_valid high for exactly 1 cycle; o_inputs unchanged.
REQ-034 Bytes 02, FF then 100 idle cycles -> o_err=1, state IDLE, o_inputs keeps its prior value.
REQ-035 Checksum build: bytes 02, 12, 01, 13 -> commit 10'h112; bytes 02, 12, 01, 00 -> o_err=1, no o_update.
REQ-036 i_rst pulsed after 02, 34 -> all outputs at reset values; next 02, 34, 01 commits 10'h134.
